// File: rtl/compm_pkg.sv
// Shared types and chunk geometry for the pipelined magnitude comparator.
package compm_pkg;

    typedef struct packed {
        logic decided;
        logic gt;
        logic lt;
    } cmp_res_t;

    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int chunk_hi(input int k, input int width, input int stages);
        return width - 1 - k * chunk_size(width, stages);
    endfunction

    // The last chunk is clipped at bit 0 and may be narrower than the rest.
    function automatic int chunk_lo(input int k, input int width, input int stages);
        int lo;
        lo = chunk_hi(k, width, stages) - chunk_size(width, stages) + 1;
        return (lo < 0) ? 0 : lo;
    endfunction

endpackage

// File: rtl/compm_stage.sv
// One comparator pipeline stage: valid/ready slot, chunk compare on bits [HI:LO],
// and forwarding of the operand bits below LO to the next stage.
module compm_stage
    import compm_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int HI    = 9,
    parameter int LO    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  cmp_res_t         up_res,
    input  logic [WIDTH-1:0] up_a,
    input  logic [WIDTH-1:0] up_b,
    output logic             dn_valid,
    input  logic             dn_ready,
    output cmp_res_t         dn_res,
    output logic [WIDTH-1:0] dn_a,
    output logic [WIDTH-1:0] dn_b
);

    logic [HI-LO:0] ca;
    logic [HI-LO:0] cb;
    cmp_res_t       nxt;
    logic           vld;
    logic           unused_bits;

    assign ca       = up_a[HI:LO];
    assign cb       = up_b[HI:LO];
    assign up_ready = !vld || dn_ready;
    assign dn_valid = vld;

    // Bits above HI were consumed by earlier stages.
    assign unused_bits = ^{up_a, up_b};

    always_comb begin
        nxt = up_res;
        if (!up_res.decided) begin
            nxt.decided = (ca != cb);
            nxt.gt      = (ca > cb);
            nxt.lt      = (ca < cb);
        end
    end

    // A bubble loads a cleared result so the flags read 0 while the slot is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld    <= 1'b0;
            dn_res <= '0;
        end else if (up_ready) begin
            vld    <= up_valid;
            dn_res <= up_valid ? nxt : cmp_res_t'('0);
        end
    end

    generate
        if (LO > 0) begin : g_rem
            logic [LO-1:0] rem_a;
            logic [LO-1:0] rem_b;

            always_ff @(posedge clk) begin
                if (up_ready && up_valid) begin
                    rem_a <= up_a[LO-1:0];
                    rem_b <= up_b[LO-1:0];
                end
            end

            assign dn_a = WIDTH'(rem_a);
            assign dn_b = WIDTH'(rem_b);
        end else begin : g_last
            assign dn_a = '0;
            assign dn_b = '0;
        end
    endgenerate

endmodule

// File: rtl/compm_pipe.sv
// Pipelined WIDTH-bit magnitude comparator, MSB-first chunks over STAGES stages.
// Optional result statistics counters are built when COMPM_STATS_EN is defined.
module compm_pipe
    import compm_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SGN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             GT,
    output logic             LT,
    output logic             EQ,
    output logic             OUT_VALID,
`ifdef COMPM_STATS_EN
    input  logic             CLR_CNT,
    output logic [CNT_W-1:0] GT_CNT,
    output logic [CNT_W-1:0] LT_CNT,
    output logic [CNT_W-1:0] EQ_CNT,
`endif
    input  logic             OUT_READY
);

    localparam int CH = chunk_size(WIDTH, (STAGES < 1) ? 1 : STAGES);

    generate
        if (STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * CH >= WIDTH) begin : g_bad_cfg
            $error("compm_pipe: STAGES=%0d gives an empty chunk for WIDTH=%0d", STAGES, WIDTH);
        end
    endgenerate

    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            rdy_pipe;
    cmp_res_t [STAGES:0]        res_pipe;
    logic [STAGES:0][WIDTH-1:0] a_pipe;
    logic [STAGES:0][WIDTH-1:0] b_pipe;
    logic [WIDTH-1:0]           msb_flip;
    logic                       unused_tail;

    // Flipping both sign bits maps two's complement onto offset binary,
    // so every stage can use a plain unsigned compare.
    assign msb_flip = SGN ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    assign vld_pipe[0]      = IN_VALID;
    assign res_pipe[0]      = '0;
    assign a_pipe[0]        = A ^ msb_flip;
    assign b_pipe[0]        = B ^ msb_flip;
    assign rdy_pipe[STAGES] = OUT_READY;
    assign IN_READY         = rdy_pipe[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            compm_stage #(
                .WIDTH (WIDTH),
                .HI    (chunk_hi(k, WIDTH, STAGES)),
                .LO    (chunk_lo(k, WIDTH, STAGES))
            ) u_stage (
                .clk      (CLK),
                .rst_n    (RST_N),
                .up_valid (vld_pipe[k]),
                .up_ready (rdy_pipe[k]),
                .up_res   (res_pipe[k]),
                .up_a     (a_pipe[k]),
                .up_b     (b_pipe[k]),
                .dn_valid (vld_pipe[k+1]),
                .dn_ready (rdy_pipe[k+1]),
                .dn_res   (res_pipe[k+1]),
                .dn_a     (a_pipe[k+1]),
                .dn_b     (b_pipe[k+1])
            );
        end
    endgenerate

    // The last stage forwards no operand bits.
    assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES]};

    assign OUT_VALID = vld_pipe[STAGES];
    assign GT        = res_pipe[STAGES].gt;
    assign LT        = res_pipe[STAGES].lt;
    assign EQ        = vld_pipe[STAGES] & ~res_pipe[STAGES].decided;

`ifdef COMPM_STATS_EN
    logic xfer;

    assign xfer = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N || CLR_CNT) begin
            GT_CNT <= '0;
            LT_CNT <= '0;
            EQ_CNT <= '0;
        end else if (xfer) begin
            if (GT && GT_CNT != '1) GT_CNT <= GT_CNT + CNT_W'(1);
            if (LT && LT_CNT != '1) LT_CNT <= LT_CNT + CNT_W'(1);
            if (EQ && EQ_CNT != '1) EQ_CNT <= EQ_CNT + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt;

    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_compm_pipe.sv
// Scoreboard bench for compm_pipe: a 2-stage instance under random traffic with
// backpressure, plus a 3-stage instance for uneven chunking latency.
module tb_compm_pipe;

    localparam int W  = 10;
    localparam int S2 = 2;
    localparam int S3 = 3;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a2, b2, a3, b3;
    logic         sgn2, iv2, ir2, gt2, lt2, eq2, ov2, or2;
    logic         sgn3, iv3, ir3, gt3, lt3, eq3, ov3, or3;
`ifdef COMPM_STATS_EN
    logic         clr2, clr3;
    logic [1:0]   gtc2, ltc2, eqc2;
    logic [15:0]  gtc3, ltc3, eqc3;
    int           m_gt, m_lt, m_eq;
`endif

    int checks   = 0;
    int failures = 0;

    logic [2:0] q2[$];
    logic       stall_prev = 1'b0;
    logic [2:0] prev_got   = 3'b000;

    compm_pipe #(.WIDTH(W), .STAGES(S2), .CNT_W(2)) u2 (
        .CLK(clk), .RST_N(rst_n), .A(a2), .B(b2), .SGN(sgn2),
        .IN_VALID(iv2), .IN_READY(ir2), .GT(gt2), .LT(lt2), .EQ(eq2),
        .OUT_VALID(ov2),
`ifdef COMPM_STATS_EN
        .CLR_CNT(clr2), .GT_CNT(gtc2), .LT_CNT(ltc2), .EQ_CNT(eqc2),
`endif
        .OUT_READY(or2)
    );

    compm_pipe #(.WIDTH(W), .STAGES(S3)) u3 (
        .CLK(clk), .RST_N(rst_n), .A(a3), .B(b3), .SGN(sgn3),
        .IN_VALID(iv3), .IN_READY(ir3), .GT(gt3), .LT(lt3), .EQ(eq3),
        .OUT_VALID(ov3),
`ifdef COMPM_STATS_EN
        .CLR_CNT(clr3), .GT_CNT(gtc3), .LT_CNT(ltc3), .EQ_CNT(eqc3),
`endif
        .OUT_READY(or3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: compare as integers, {gt, lt, eq}.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int va, vb;
        va = int'(a);
        vb = int'(b);
        if (s) begin
            if (va >= (1 << (W - 1))) va -= (1 << W);
            if (vb >= (1 << (W - 1))) vb -= (1 << W);
        end
        return {va > vb, va < vb, va == vb};
    endfunction

    // Monitor for the 2-stage instance; all signals are stable at the falling edge.
    always @(negedge clk) begin
        logic [2:0] got;
        logic [2:0] exp;
        logic       xfer;
        logic       exp_ir;
        got  = {gt2, lt2, eq2};
        exp  = 3'b000;
        xfer = ov2 && or2;
        if (!rst_n) begin
            q2.delete();
            stall_prev = 1'b0;
`ifdef COMPM_STATS_EN
            m_gt = 0; m_lt = 0; m_eq = 0;
`endif
        end else begin
            chk("flags_onehot", ov2 ? ($countones(got) == 1) : (got == 3'b000), int'(got), int'(ov2));
            exp_ir = !(q2.size() == S2 && !or2);
            chk("in_ready", ir2 == exp_ir, int'(ir2), int'(exp_ir));
            if (stall_prev)
                chk("stall_hold", ov2 && got == prev_got, int'({ov2, got}), int'({1'b1, prev_got}));
`ifdef COMPM_STATS_EN
            chk("gt_cnt", int'(gtc2) == m_gt, int'(gtc2), m_gt);
            chk("lt_cnt", int'(ltc2) == m_lt, int'(ltc2), m_lt);
            chk("eq_cnt", int'(eqc2) == m_eq, int'(eqc2), m_eq);
`endif
            if (xfer) begin
                chk("out_expected", q2.size() != 0, int'(got), 0);
                if (q2.size() != 0) begin
                    exp = q2.pop_front();
                    chk("result", got == exp, int'(got), int'(exp));
                end
            end
`ifdef COMPM_STATS_EN
            if (clr2) begin
                m_gt = 0; m_lt = 0; m_eq = 0;
            end else if (xfer) begin
                if (exp[2] && m_gt < 3) m_gt++;
                if (exp[1] && m_lt < 3) m_lt++;
                if (exp[0] && m_eq < 3) m_eq++;
            end
`endif
            if (iv2 && ir2) q2.push_back(model(a2, b2, sgn2));
            stall_prev = ov2 && !or2;
            prev_got   = got;
        end
    end

    task automatic send2(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int   n;
        logic go;
        a2 = a; b2 = b; sgn2 = s; iv2 = 1'b1;
        n = 0; go = 1'b0;
        while (!go && n < 200) begin
            @(negedge clk);
            go = ir2;
            @(posedge clk);
            #1;
            n++;
        end
        iv2 = 1'b0;
        chk("send_accept", go, n, 200);
    endtask

    // Unstalled latency: result must appear after exactly two edges.
    task automatic dir2(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [2:0] exp);
        or2 = 1'b1;
        send2(a, b, s);
        chk("lat2_early", ov2 == 1'b0, int'(ov2), 0);
        @(posedge clk);
        #1;
        chk("lat2_result", ov2 && {gt2, lt2, eq2} == exp, int'({ov2, gt2, lt2, eq2}), int'({1'b1, exp}));
    endtask

    task automatic dir3(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [2:0] exp;
        exp = model(a, b, s);
        a3 = a; b3 = b; sgn3 = s; iv3 = 1'b1;
        @(negedge clk);
        chk("ir3", ir3 == 1'b1, int'(ir3), 1);
        @(posedge clk);
        #1;
        iv3 = 1'b0;
        chk("lat3_e1", ov3 == 1'b0, int'(ov3), 0);
        @(posedge clk);
        #1;
        chk("lat3_e2", ov3 == 1'b0, int'(ov3), 0);
        @(posedge clk);
        #1;
        chk("lat3_result", ov3 && {gt3, lt3, eq3} == exp, int'({ov3, gt3, lt3, eq3}), int'({1'b1, exp}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   sent, cyc, n;
        logic go;
        rst_n = 1'b0;
        a2 = '0; b2 = '0; sgn2 = 1'b0; iv2 = 1'b0; or2 = 1'b1;
        a3 = '0; b3 = '0; sgn3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
`ifdef COMPM_STATS_EN
        clr2 = 1'b0; clr3 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", ov2 == 1'b0, int'(ov2), 0);
        chk("rst_flags", {gt2, lt2, eq2} == 3'b000, int'({gt2, lt2, eq2}), 0);
        chk("rst_in_ready", ir2 == 1'b1, int'(ir2), 1);
        chk("rst_out_valid3", ov3 == 1'b0, int'(ov3), 0);
        rst_n = 1'b1;

        dir2(10'd512, 10'd511, 1'b0, 3'b100);
        dir2(10'd1023, 10'd1023, 1'b0, 3'b001);
        dir2(10'd0, 10'd1, 1'b0, 3'b010);
        dir2(10'h3FF, 10'h001, 1'b1, 3'b010);
        dir2(10'h3FF, 10'h001, 1'b0, 3'b100);

        dir3(10'h201, 10'h200, 1'b0);
        dir3(10'h200, 10'h201, 1'b0);
        dir3(10'h155, 10'h155, 1'b1);
        dir3(10'h3FF, 10'h000, 1'b1);

        // Random stream with random backpressure and occasional input gaps.
        sent = 0; cyc = 0;
        while (sent < 100 && cyc < 5000) begin
            if (!iv2 && $urandom_range(0, 3) != 0) begin
                a2   = W'($urandom_range(0, 1023));
                b2   = ($urandom_range(0, 3) == 0) ? a2 : W'($urandom_range(0, 1023));
                sgn2 = 1'($urandom_range(0, 1));
                iv2  = 1'b1;
            end
            or2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            go = iv2 && ir2;
            @(posedge clk);
            #1;
            if (go) begin
                sent++;
                iv2 = 1'b0;
            end
            cyc++;
        end
        chk("random_sent", sent == 100, sent, 100);
        or2 = 1'b1;
        n = 0;
        while (q2.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", q2.size() == 0, q2.size(), 0);

        // Two samples in flight, then a one-cycle reset.
        or2 = 1'b0;
        send2(10'd100, 10'd200, 1'b0);
        send2(10'd300, 10'd300, 1'b1);
        chk("full_in_ready", ir2 == 1'b0, int'(ir2), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", ov2 == 1'b0, int'(ov2), 0);
        chk("midrst_in_ready", ir2 == 1'b1, int'(ir2), 1);
        or2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_flush", ov2 == 1'b0, int'(ov2), 0);

`ifdef COMPM_STATS_EN
        clr2 = 1'b1;
        @(posedge clk);
        #1;
        clr2 = 1'b0;
        chk("clr_gt_cnt", gtc2 == 2'd0, int'(gtc2), 0);
        repeat (5) send2(10'd512, 10'd511, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("gt_cnt_sat", gtc2 == 2'd3, int'(gtc2), 3);
        send2(10'd600, 10'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("clr_coincide_ov", ov2 == 1'b1, int'(ov2), 1);
        clr2 = 1'b1;
        @(posedge clk);
        #1;
        clr2 = 1'b0;
        chk("clr_priority", gtc2 == 2'd0, int'(gtc2), 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
